// File: rtl/sequence_frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_frame_transmitter
//  Description : Serialises a parallel payload into a framed bit stream. Each
//                frame is the sync word 1011 (MSB first) followed by the payload
//                (MSB first). A 0 is stuffed after every emitted 101 in the
//                payload so that 1011 only ever appears in the sync field.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_frame_transmitter #(
    parameter int DATA_WIDTH = 8,   // payload width, >= 4
    parameter int GAP_CYCLES = 1    // idle-0 cycles after each frame, >= 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  frame_active,
    output logic                  stuff_bit,
    output logic                  frame_done
);

    // One counter serves the sync index, the payload bit count and the gap
    // count, so it is sized for the largest of the three.
    localparam int c_CNT_MAX = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_PREAMBLE = 2'd1;
    localparam logic [1:0] c_ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] c_ST_GAP      = 2'd3;

    localparam logic [3:0]      c_SYNC       = 4'b1011;
    localparam logic [2:0]      c_STUFF_HIST = 3'b101;
    localparam logic [c_CW-1:0] c_ZERO       = '0;
    localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);
    localparam logic [c_CW-1:0] c_PRE_LAST   = c_CW'(3);
    localparam logic [c_CW-1:0] c_DATA_LEN   = c_CW'(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP_CYCLES - 1);

    logic [1:0]            r_state;
    logic [c_CW-1:0]       r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_hist;    // last three line bits, oldest..newest

    logic [1:0]            w_state_next;
    logic [c_CW-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_serial;
    logic                  w_stuff;
    logic                  w_active;
    logic                  w_done;
    logic                  w_ready;
    logic [1:0]            w_sync_idx;
    logic                  w_last_makes_101;

    // Sync bits are indexed MSB first by the preamble counter.
    assign w_sync_idx = 2'd3 - r_count[1:0];

    // Would emitting the current shift-register MSB leave 101 in the history?
    assign w_last_makes_101 = ({r_hist[1:0], r_shift[DATA_WIDTH-1]} == c_STUFF_HIST);

    // State, counter, shift register and line history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= c_ZERO;
            r_shift <= '0;
            r_hist  <= 3'b000;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_shift <= w_shift_next;
            r_hist  <= {r_hist[1:0], w_serial};
        end
    end

    // Next-state logic and Moore outputs decoded from the registers.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_shift_next = r_shift;
        w_serial     = 1'b0;
        w_stuff      = 1'b0;
        w_active     = 1'b0;
        w_done       = 1'b0;
        w_ready      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (data_valid) begin
                    w_shift_next = data_in;
                    w_count_next = c_ZERO;
                    w_state_next = c_ST_PREAMBLE;
                end
            end

            c_ST_PREAMBLE: begin
                w_active = 1'b1;
                w_serial = c_SYNC[w_sync_idx];
                if (r_count == c_PRE_LAST) begin
                    w_count_next = c_DATA_LEN;
                    w_state_next = c_ST_PAYLOAD;
                end else begin
                    w_count_next = r_count + c_ONE;
                end
            end

            c_ST_PAYLOAD: begin
                w_active = 1'b1;
                if (r_hist == c_STUFF_HIST) begin
                    // Stuffed 0: payload and count hold. At count 0 this is
                    // the trailing stuff and the frame ends here.
                    w_stuff = 1'b1;
                    if (r_count == c_ZERO) begin
                        w_state_next = c_ST_GAP;
                    end
                end else if (r_count == c_ZERO) begin
                    // Only reachable through a trailing stuff; close defensively.
                    w_state_next = c_ST_GAP;
                end else begin
                    w_serial     = r_shift[DATA_WIDTH-1];
                    w_shift_next = r_shift << 1;
                    w_count_next = r_count - c_ONE;
                    // Last data bit: linger at count 0 only if a trailing
                    // stuff is owed, otherwise go straight to the gap.
                    if ((r_count == c_ONE) && !w_last_makes_101) begin
                        w_state_next = c_ST_GAP;
                    end
                end
            end

            c_ST_GAP: begin
                w_done = (r_count == c_ZERO);
                if (r_count == c_GAP_LAST) begin
                    w_count_next = c_ZERO;
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_count_next = r_count + c_ONE;
                end
            end

            default: begin
                w_state_next = c_ST_IDLE;
                w_count_next = c_ZERO;
            end
        endcase
    end

    assign data_ready   = w_ready;
    assign serial_out   = w_serial;
    assign frame_active = w_active;
    assign stuff_bit    = w_stuff;
    assign frame_done   = w_done;

endmodule
`default_nettype wire

// File: tb/tb_sequence_frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_frame_transmitter
//  Description : Directed frames with hand-derived line patterns, a
//                back-to-back random run checked by a destuffing receiver and
//                a 1011 detector model, and a mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_frame_transmitter;

    localparam int c_DW  = 8;
    localparam int c_GAP = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [c_DW-1:0] data_in = '0;
    logic            data_valid = 1'b0;
    logic            data_ready;
    logic            serial_out;
    logic            frame_active;
    logic            stuff_bit;
    logic            frame_done;

    int n_chk = 0;
    int n_bad = 0;

    sequence_frame_transmitter #(
        .DATA_WIDTH (c_DW),
        .GAP_CYCLES (c_GAP)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .stuff_bit    (stuff_bit),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One directed frame: bits/stuff hold the expected line pattern, first
    // frame cycle in bit len-1.
    task automatic run_frame(input string tag, input logic [7:0] d,
                             input logic [15:0] bits, input logic [15:0] stf,
                             input int len);
        logic [15:0] got_b;
        logic [15:0] got_s;
        int          act_bad;
        got_b   = '0;
        got_s   = '0;
        act_bad = 0;
        chk({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = ~d;
        for (int i = 0; i < len; i++) begin
            got_b = {got_b[14:0], serial_out};
            got_s = {got_s[14:0], stuff_bit};
            if (!frame_active) act_bad++;
            tick();
        end
        chk({tag, "_bits"}, {16'd0, got_b}, {16'd0, bits});
        chk({tag, "_stuff"}, {16'd0, got_s}, {16'd0, stf});
        chk({tag, "_active"}, act_bad, 0);
        chk({tag, "_gap_active"}, {31'd0, frame_active}, 32'd0);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_gap_line"}, {31'd0, serial_out}, 32'd0);
        tick();
        chk({tag, "_done_once"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, data_ready}, 32'd1);
    endtask

    // Receiver-side model used during the back-to-back run.
    bit         mon_en = 1'b0;
    int         cyc = 0;
    int         hs_cyc = -1;
    int         last_flen = 0;
    int         flen = 0;
    int         det_in_frame = 0;
    int         n_hs = 0;
    int         n_frames = 0;
    logic [3:0] det_sh = 4'b0000;
    logic [7:0] pay_q[$];
    logic       line_q[$];
    logic       stf_q[$];

    // Mid-cycle sampling: detector, frame capture/destuff, handshake record.
    always @(negedge clock) begin
        if (mon_en) begin
            det_sh = {det_sh[2:0], serial_out};
            if (det_sh == 4'b1011) begin
                det_in_frame++;
                chk("det_latency", cyc - hs_cyc, 4);
            end
            if (frame_active) begin
                line_q.push_back(serial_out);
                stf_q.push_back(stuff_bit);
                flen++;
            end
            if (frame_done) begin
                logic [2:0] h;
                logic [7:0] got;
                logic [3:0] sync;
                logic [7:0] want;
                int         nd;
                int         serr;
                h    = 3'b011;
                got  = '0;
                sync = '0;
                nd   = 0;
                serr = 0;
                for (int i = 0; i < line_q.size(); i++) begin
                    if (i < 4) begin
                        sync = {sync[2:0], line_q[i]};
                        if (stf_q[i]) serr++;
                    end else begin
                        if (h == 3'b101) begin
                            if (line_q[i] != 1'b0 || !stf_q[i]) serr++;
                        end else begin
                            got = {got[6:0], line_q[i]};
                            nd++;
                            if (stf_q[i]) serr++;
                        end
                        h = {h[1:0], line_q[i]};
                    end
                end
                want = (pay_q.size() > 0) ? pay_q.pop_front() : 8'hxx;
                chk("rx_sync", {28'd0, sync}, 32'h0000000B);
                chk("rx_payload", {24'd0, got}, {24'd0, want});
                chk("rx_ndata", nd, c_DW);
                chk("rx_stuff_flags", serr, 0);
                chk("det_per_frame", det_in_frame, 1);
                det_in_frame = 0;
                last_flen    = flen;
                flen         = 0;
                line_q.delete();
                stf_q.delete();
                n_frames++;
            end
            if (data_valid && data_ready) begin
                if (hs_cyc >= 0) chk("hs_spacing", cyc - hs_cyc, last_flen + c_GAP + 1);
                hs_cyc = cyc;
                pay_q.push_back(data_in);
                n_hs++;
            end
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_line", {31'd0, serial_out}, 32'd0);
        chk("rst_active", {31'd0, frame_active}, 32'd0);
        chk("rst_stuff", {31'd0, stuff_bit}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd1);
        reset = 1'b0;
        tick();

        run_frame("f00", 8'h00, 16'h0B00, 16'h0000, 12);
        run_frame("fFF", 8'hFF, 16'h0BFF, 16'h0000, 12);
        run_frame("fB6", 8'hB6, 16'h2EA6, 16'h0050, 14);
        run_frame("fAA", 8'hAA, 16'h2E94, 16'h0042, 14);
        run_frame("f05", 8'h05, 16'h160A, 16'h0001, 13);

        // Back-to-back random payloads with data_valid held high.
        mon_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            data_valid = 1'b1;
            data_in    = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        repeat (30) tick();
        mon_en = 1'b0;
        chk("rx_frames", n_frames, n_hs);
        chk("rx_min_frames", {31'd0, (n_hs >= 5)}, 32'd1);

        // Reset during the 3rd payload cycle of an all-ones frame.
        data_in    = 8'hFF;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (6) tick();
        chk("abort_pre_line", {31'd0, serial_out}, 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_line", {31'd0, serial_out}, 32'd0);
        chk("abort_ready", {31'd0, data_ready}, 32'd1);
        chk("abort_active", {31'd0, frame_active}, 32'd0);
        chk("abort_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | frame_done | serial_out;
        end
        chk("abort_quiet", {31'd0, seen}, 32'd0);

        run_frame("f00b", 8'h00, 16'h0B00, 16'h0000, 12);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sequence_frame_transmitter.md
Name: sequence_frame_transmitter

Overview:
- Serial framer that turns a parallel payload word into a one-bit-per-clock stream.
- Each frame is the sync pattern 1011, MSB first, followed by the payload MSB first.
- The payload is zero-stuffed so the pattern 1011 can never appear anywhere except in the sync field.
- It drives the serial line that the team's 1011 Moore sequence detector monitors; it is the transmit end of that link.

Parameters:
- DATA_WIDTH, default 8: payload width in bits; minimum 4.
- GAP_CYCLES, default 1: idle-0 cycles forced after each frame; minimum 1.

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  payload word; sampled on handshake.
- data_valid  input  1  payload offered.
- data_ready  output  1  high only in IDLE; handshake = data_valid & data_ready at a rising edge.
- serial_out  output  1  line bit; 0 when no frame is in progress.
- frame_active  output  1  high during sync, payload and stuffed bits.
- stuff_bit  output  1  high while serial_out carries an inserted stuffed 0.
- frame_done  output  1  one-cycle pulse in the first GAP cycle.

Behaviour:
- Reset values (reset sampled high at an edge):
  - state=IDLE, hist=000, bit counter=0.
  - serial_out=0, frame_active=0, stuff_bit=0, frame_done=0, data_ready=1.
  - Reset wins over every other event, including mid-frame; the aborted frame is dropped and no frame_done is issued.
- Outputs are Moore-style: derived only from registered state, shift register, counters and hist. No combinational path from inputs to outputs except data_ready, which depends on state only.
- hist is a 3-bit register holding the last three emitted bits (oldest..newest). It shifts in serial_out every cycle in every state.
- Handshake:
  - In IDLE, data_valid=1 at an edge latches data_in into the shift register; next state is PREAMBLE.
  - data_valid outside IDLE is ignored; data_in may change freely.
- States:
  - IDLE: serial_out=0. Leaves to PREAMBLE on handshake.
  - PREAMBLE: 4 cycles emitting 1,0,1,1, never stuffed. Then PAYLOAD with counter=DATA_WIDTH.
  - PAYLOAD, counter>0:
    - If hist==101, emit stuffed 0 (stuff_bit=1); shift register and counter hold.
    - Otherwise emit shift-register MSB, shift left, decrement counter.
  - PAYLOAD, counter==0:
    - If hist==101, emit one trailing stuffed 0, then GAP.
    - Otherwise go to GAP directly, with no cycle spent at counter==0.
  - GAP: GAP_CYCLES cycles, serial_out=0, frame_active=0. frame_done=1 in the first GAP cycle only. Then IDLE.
- Latency and length:
  - First sync bit appears in the cycle after the handshake edge.
  - Frame length = 4 + DATA_WIDTH + S cycles, where S = number of stuffed bits.
  - Minimum spacing between handshakes = frame length + GAP_CYCLES + 1.
- Stuffing rule: a 0 is inserted after every emitted 101 inside the payload.
  - Consequence: a downstream 1011 detector fires exactly once per frame, on the last sync bit.
  - The receiver removes the 0 following any payload 101.

Test Plan:
- Reset, then data_in=8'h00 handshake:
  - serial_out over 12 cycles is 1011 00000000; stuff_bit never high.
  - frame_done pulses once; data_ready returns after GAP.
- 8'hFF: 1011 11111111, no stuffs, 12 frame cycles.
- 8'hB6: payload wire bits 1,0,1,[0],1,[0],0,1,1,0.
  - stuff_bit high on the 4th and 6th payload cycles; frame 14 cycles.
- 8'hAA: payload wire bits 1,0,1,[0],0,1,0,1,[0],0; frame 14 cycles.
- 8'h05: payload wire bits 0,0,0,0,0,1,0,1,[0].
  - Trailing stuff present with frame_active=1; frame 13 cycles.
- Random payloads, back-to-back data_valid=1:
  - Reference detector model pulses once per frame, 4 cycles after each handshake.
  - Reset asserted on the 3rd payload cycle forces serial_out=0 and IDLE next cycle, with no frame_done.
